// File: rtl/uart_rx_frame.sv
// UART receiver: 2-FF input synchroniser, mid-bit sampling frame decoder and result FIFO.
// Each FIFO entry holds {ferr, perr, data}; outputs read zero whenever the FIFO is empty.
module uart_rx_frame #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rxd,
    input  logic                             rx_ready,
    input  logic                             err_clr,
    output logic                             rx_valid,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_perr,
    output logic                             rx_ferr,
    output logic                             rx_ovr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int WW = DATA_BITS + 2;
    localparam logic [CW-1:0] HALF     = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);
    localparam logic          PEN      = (PARITY_EN != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic                   rxd_meta, rxd_sync;
    logic                   push, push_ferr, tick;
    logic [WW-1:0]          push_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign tick = (cnt_q == LAST_CNT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        push_ferr = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (!rxd_sync) state_d = START;
            end
            START: begin
                // A start bit that is high again at mid-bit is treated as a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rxd_sync ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rxd_sync, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) state_d = PEN ? PARITY : STOP1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = rxd_sync ^ (^shreg_q) ^ ODD;
                    state_d = STOP1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP1, STOP2: begin
                // Leaving at mid final stop bit lets a following start edge be seen without a gap.
                if (tick) begin
                    cnt_d = '0;
                    if (state_q == STOP1 && STOP_BITS == 2) begin
                        ferr_d  = ferr_q | ~rxd_sync;
                        state_d = STOP2;
                    end else begin
                        push      = 1'b1;
                        push_ferr = ferr_q | ~rxd_sync;
                        state_d   = rxd_sync ? IDLE : BRK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BRK_WAIT: begin
                if (rxd_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_word = {push_ferr, perr_q, shreg_q};

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          full, pop, do_push, drop;
    logic [WW-1:0] head;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = rx_valid & rx_ready;
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rx_ovr <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop)         rx_ovr <= 1'b1;
            else if (err_clr) rx_ovr <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign rx_valid   = (level != '0);
    assign rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_perr    = rx_valid & head[DATA_BITS];
    assign rx_ferr    = rx_valid & head[DATA_BITS+1];
    assign fifo_level = level;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: instance A is 8E1 (CLK_DIV=16), instance B is 7N2 (CLK_DIV=13).
// Table vectors, hand sequences for break/glitch/overrun/reset, then random frames against a queue model.
module tb_uart_rx_frame;
    localparam int DIV_A = 16;
    localparam int DIV_B = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
    logic       val_a, perr_a, ferr_a, ovr_a;
    logic [7:0] data_a;
    logic [2:0] lvl_a;
    logic       rxd_b = 1'b1, rdy_b = 1'b0, clr_b = 1'b0;
    logic       val_b, perr_b, ferr_b, ovr_b;
    logic [6:0] data_b;
    logic [2:0] lvl_b;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    typedef struct {
        logic [7:0] din;
        logic       flip;
        logic       bad_stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_rx_frame #(.CLK_DIV(DIV_A), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx_ready(rdy_a), .err_clr(clr_a),
        .rx_valid(val_a), .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
        .rx_ovr(ovr_a), .fifo_level(lvl_a));

    uart_rx_frame #(.CLK_DIV(DIV_B), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx_ready(rdy_b), .err_clr(clr_b),
        .rx_valid(val_b), .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
        .rx_ovr(ovr_b), .fifo_level(lvl_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    // Called at a negedge; drives one whole frame and returns at the negedge ending it.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic flip,
                              input logic bad_stop);
        int nb, div, nst;
        logic par;
        nb  = (sel == 0) ? 8 : 7;
        div = (sel == 0) ? DIV_A : DIV_B;
        nst = (sel == 0) ? 1 : 2;
        par = flip;
        set_line(sel, 1'b0);
        repeat (div) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            set_line(sel, data[i]);
            par = par ^ data[i];
            repeat (div) @(negedge clk);
        end
        if (sel == 0) begin
            set_line(0, par);
            repeat (div) @(negedge clk);
        end
        for (int i = 0; i < nst; i++) begin
            set_line(sel, ~bad_stop);
            repeat (div) @(negedge clk);
        end
        set_line(sel, 1'b1);
        if (bad_stop) repeat (div) @(negedge clk);
    endtask

    task automatic pop_check(input int sel, input logic [7:0] ed, input logic ep,
                             input logic ef, input string name);
        logic v, p, f;
        logic [7:0] d;
        v = (sel == 0) ? val_a : val_b;
        d = (sel == 0) ? data_a : {1'b0, data_b};
        p = (sel == 0) ? perr_a : perr_b;
        f = (sel == 0) ? ferr_a : ferr_b;
        check({name, ".valid"}, {31'd0, v}, 32'd1);
        check({name, ".data"},  {24'd0, d}, {24'd0, ed});
        check({name, ".perr"},  {31'd0, p}, {31'd0, ep});
        check({name, ".ferr"},  {31'd0, f}, {31'd0, ef});
        if (sel == 0) rdy_a = 1'b1;
        else          rdy_b = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    task automatic pulse_clr_a();
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
    endtask

    // Reference model: an entry is queued unless four are already waiting.
    task automatic model_frame(input logic [7:0] d, input logic flip, input logic bad);
        if (exp_q.size() < 4) exp_q.push_back({bad, flip, d});
        else                  exp_ovr = 1'b1;
    endtask

    task automatic model_pop();
        logic [9:0] e;
        e = exp_q.pop_front();
        pop_check(0, e[7:0], e[8], e[9], "rand");
    endtask

    initial begin
        vecs[0] = '{8'hFA, 1'b0, 1'b0, 8'hFA, 1'b0, 1'b0};
        vecs[1] = '{8'hE1, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[2] = '{8'hDA, 1'b0, 1'b0, 8'hDA, 1'b0, 1'b0};
        vecs[3] = '{8'hE1, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[4] = '{8'hDA, 1'b1, 1'b0, 8'hDA, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst.valid", {31'd0, val_a}, 32'd0);
        check("rst.level", {29'd0, lvl_a}, 32'd0);
        check("rst.ovr",   {31'd0, ovr_a}, 32'd0);
        check("rst.data",  {24'd0, data_a}, 32'd0);
        check("rst.perr",  {31'd0, perr_a}, 32'd0);
        check("rst.ferr",  {31'd0, ferr_a}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Four back-to-back frames held, then drained in order.
        for (int i = 0; i < 4; i++) send_frame(0, vecs[i].din, vecs[i].flip, vecs[i].bad_stop);
        check("t1.level", {29'd0, lvl_a}, 32'd4);
        for (int i = 0; i < 4; i++)
            pop_check(0, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, $sformatf("vec%0d", i));
        for (int i = 4; i < 8; i++) begin
            send_frame(0, vecs[i].din, vecs[i].flip, vecs[i].bad_stop);
            check($sformatf("vec%0d.level", i), {29'd0, lvl_a}, 32'd1);
            pop_check(0, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, $sformatf("vec%0d", i));
        end

        // Line break of 20 bit times, then a clean frame.
        set_line(0, 1'b0);
        repeat (20 * DIV_A) @(negedge clk);
        set_line(0, 1'b1);
        repeat (3 * DIV_A) @(negedge clk);
        send_frame(0, 8'h55, 1'b0, 1'b0);
        check("brk.level", {29'd0, lvl_a}, 32'd2);
        pop_check(0, 8'h00, 1'b0, 1'b1, "brk");
        pop_check(0, 8'h55, 1'b0, 1'b0, "brk_next");
        check("brk.empty", {31'd0, val_a}, 32'd0);

        // Start glitch shorter than half a bit.
        set_line(0, 1'b0);
        repeat (DIV_A / 4) @(negedge clk);
        set_line(0, 1'b1);
        repeat (3 * DIV_A) @(negedge clk);
        check("glitch.level", {29'd0, lvl_a}, 32'd0);
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        pop_check(0, 8'hA5, 1'b0, 1'b0, "glitch_next");

        // Overrun: fifth frame dropped, sticky flag until cleared.
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i * 17), 1'b0, 1'b0);
        check("ovr.level", {29'd0, lvl_a}, 32'd4);
        check("ovr.flag",  {31'd0, ovr_a}, 32'd1);
        for (int i = 1; i <= 4; i++) pop_check(0, 8'(i * 17), 1'b0, 1'b0, $sformatf("ovr%0d", i));
        check("ovr.sticky", {31'd0, ovr_a}, 32'd1);
        pulse_clr_a();
        check("ovr.cleared", {31'd0, ovr_a}, 32'd0);

        // Pop lands on the same clock as the fifth push: 3 sync/idle cycles, half bit, then 10 bit times.
        for (int i = 1; i <= 4; i++) send_frame(0, 8'h60 + 8'(i), 1'b0, 1'b0);
        check("sim.head", {24'd0, data_a}, 32'h61);
        fork
            send_frame(0, 8'h65, 1'b0, 1'b0);
            begin
                repeat (DIV_A / 2 + 3 + 10 * DIV_A) @(negedge clk);
                rdy_a = 1'b1;
                @(negedge clk);
                rdy_a = 1'b0;
            end
        join
        check("sim.level", {29'd0, lvl_a}, 32'd4);
        check("sim.ovr",   {31'd0, ovr_a}, 32'd0);
        for (int i = 2; i <= 5; i++) pop_check(0, 8'h60 + 8'(i), 1'b0, 1'b0, $sformatf("sim%0d", i));

        // Reset during data bit 3 with one entry already held.
        send_frame(0, 8'h33, 1'b0, 1'b0);
        set_line(0, 1'b0);
        repeat (DIV_A) @(negedge clk);
        set_line(0, 1'b1);
        repeat (DIV_A) @(negedge clk);
        set_line(0, 1'b0);
        repeat (2 * DIV_A) @(negedge clk);
        repeat (DIV_A / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst.valid", {31'd0, val_a}, 32'd0);
        check("mrst.level", {29'd0, lvl_a}, 32'd0);
        check("mrst.data",  {24'd0, data_a}, 32'd0);
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20 * DIV_A) @(negedge clk);
        check("mrst.nopartial", {29'd0, lvl_a}, 32'd0);
        send_frame(0, 8'hE1, 1'b0, 1'b0);
        check("mrst.level", {29'd0, lvl_a}, 32'd1);
        pop_check(0, 8'hE1, 1'b0, 1'b0, "mrst_next");

        // 7N2 instance: four back-to-back frames, then a framing error.
        send_frame(1, 8'h7A, 1'b0, 1'b0);
        send_frame(1, 8'h61, 1'b0, 1'b0);
        send_frame(1, 8'h5A, 1'b0, 1'b0);
        send_frame(1, 8'h61, 1'b0, 1'b0);
        check("b.level", {29'd0, lvl_b}, 32'd4);
        pop_check(1, 8'h7A, 1'b0, 1'b0, "b0");
        pop_check(1, 8'h61, 1'b0, 1'b0, "b1");
        pop_check(1, 8'h5A, 1'b0, 1'b0, "b2");
        pop_check(1, 8'h61, 1'b0, 1'b0, "b3");
        send_frame(1, 8'h2B, 1'b0, 1'b1);
        pop_check(1, 8'h2B, 1'b0, 1'b1, "b_ferr");
        check("b.ovr", {31'd0, ovr_b}, 32'd0);

        // Random frames against the queue model.
        exp_q.delete();
        exp_ovr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic flip, bad;
            int npop;
            d    = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 7) == 0);
            bad  = ($urandom_range(0, 9) == 0);
            send_frame(0, d, flip, bad);
            model_frame(d, flip, bad);
            check("rand.level", {29'd0, lvl_a}, exp_q.size());
            check("rand.ovr",   {31'd0, ovr_a}, {31'd0, exp_ovr});
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++)
                if (exp_q.size() > 0) model_pop();
            if ($urandom_range(0, 5) == 0) begin
                pulse_clr_a();
                exp_ovr = 1'b0;
            end
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        while (exp_q.size() > 0) model_pop();
        check("rand.drained", {31'd0, val_a}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
